// File: rtl/pe_dot_pkg.sv
// Shared helpers for the PE dot-product accumulator: adder-tree geometry and result record.
package pe_dot_pkg;

  localparam int RES_SUM_W = 32;
  localparam int RES_CNT_W = 16;

  // Default result record; the top re-declares it at its own ACC_W/CNT_W.
  typedef struct packed {
    logic signed [RES_SUM_W-1:0] sum;
    logic        [RES_CNT_W-1:0] chunks;
  } res_t;

  // Number of ternary reduction levels (= register stages) for num inputs.
  function automatic int tree_lat(input int num);
    int n;
    int lat;
    n   = num;
    lat = 1;
    while (n > 3) begin
      n   = (n + 2) / 3;
      lat = lat + 1;
    end
    return lat;
  endfunction

  // Output width of the tree: each ternary level grows the sum by two bits.
  function automatic int tree_w(input int din_w, input int num);
    return din_w + 2 * (tree_lat(num) - 1) + 2;
  endfunction

  // Operand count remaining after lvl ternary reductions of num inputs.
  function automatic int lvl_cnt(input int num, input int lvl);
    int n;
    n = num;
    for (int i = 0; i < lvl; i++) n = (n + 2) / 3;
    return n;
  endfunction

endpackage

// File: rtl/pe_a10_adder_tree.sv
// Stall-free pipelined ternary adder tree: one register stage per reduction level.
// Datapath is unreset; qualification is the caller's job.
module pe_a10_adder_tree
  import pe_dot_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int NUM      = 4,
  parameter int OUT_SIZE = tree_w(SIZE, NUM)
) (
  input  logic                  clk,
  input  logic [NUM*SIZE-1:0]   din,
  output logic [OUT_SIZE-1:0]   dout
);

  localparam int LAT = tree_lat(NUM);

  logic signed [OUT_SIZE-1:0] lv_in [LAT][NUM];
  logic signed [OUT_SIZE-1:0] lv_d  [LAT][NUM];
  logic signed [OUT_SIZE-1:0] lv_q  [LAT][NUM];

  // Level inputs: sign-extended lanes feed level 0, each later level reads the previous register.
  always_comb begin
    for (int j = 0; j < NUM; j++) lv_in[0][j] = OUT_SIZE'($signed(din[j*SIZE +: SIZE]));
    for (int l = 1; l < LAT; l++) lv_in[l] = lv_q[l-1];
  end

  // Ternary reduction: output j of a level sums inputs 3j..3j+2 that exist; unused slots stay 0.
  always_comb begin
    for (int l = 0; l < LAT; l++) begin
      for (int j = 0; j < NUM; j++) begin
        lv_d[l][j] = '0;
        if (j < lvl_cnt(NUM, l + 1)) begin
          for (int k = 0; k < 3; k++) begin
            if (3 * j + k < lvl_cnt(NUM, l)) lv_d[l][j] = lv_d[l][j] + lv_in[l][3*j+k];
          end
        end
      end
    end
  end

  // Pipeline registers, advancing every cycle.
  always_ff @(posedge clk) begin
    lv_q <= lv_d;
  end

  assign dout = lv_q[LAT-1][0];

endmodule

// File: rtl/pe_res_fifo.sv
// Small synchronous result FIFO with occupancy count. Pop on empty is ignored;
// push and pop on the same edge keep the count and the order.
module pe_res_fifo
  import pe_dot_pkg::*;
#(
  parameter type T     = res_t,
  parameter int  DEPTH = 4,
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 when empty after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pe_dot_accum_ctrl.sv
// Frame accumulator around the stall-free adder tree. Chunks are tracked by a
// valid/last shift register; each frame's sum lands in a result FIFO. Input is
// throttled by credits so every last chunk in flight already owns a FIFO slot.
module pe_dot_accum_ctrl
  import pe_dot_pkg::*;
#(
  parameter int NUM       = 4,
  parameter int DIN_W     = 8,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16,
  parameter int RES_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM*DIN_W-1:0]   in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum,
  output logic [CNT_W-1:0]       out_chunks,
  output logic                   busy
);

  localparam int LAT    = tree_lat(NUM);
  localparam int TREE_W = tree_w(DIN_W, NUM);
  localparam int FCW    = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic        [CNT_W-1:0] chunks;
  } res_w_t;

  logic                     accept;
  logic [LAT-1:0]           vld_pipe, lst_pipe;
  logic                     tail_v, tail_l;
  logic [TREE_W-1:0]        tree_dout;
  logic signed [ACC_W-1:0]  dext, acc, sum_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     push;
  res_w_t                   push_res, head;
  logic [FCW-1:0]           fifo_cnt;

  assign accept = in_valid && in_ready;

  // Credit check: FIFO entries plus lasts still in the tree must leave a free slot.
  assign in_ready = (int'(fifo_cnt) + $countones(lst_pipe)) < RES_DEPTH;

  pe_a10_adder_tree #(
    .SIZE     (DIN_W),
    .NUM      (NUM),
    .OUT_SIZE (TREE_W)
  ) u_tree (
    .clk  (clk),
    .din  (in_data),
    .dout (tree_dout)
  );

  // Valid/last tracking, aligned with the tree's register stages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      lst_pipe[0] <= accept && in_last;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
    end
  end

  assign tail_v  = vld_pipe[LAT-1];
  assign tail_l  = lst_pipe[LAT-1];
  assign dext    = ACC_W'($signed(tree_dout));
  assign sum_nxt = acc + dext;
  assign cnt_nxt = cnt + CNT_W'(1);

  assign push            = tail_v && tail_l;
  assign push_res.sum    = sum_nxt;
  assign push_res.chunks = cnt_nxt;

  // Frame accumulation: a retiring last hands its total to the FIFO and restarts the frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      cnt <= '0;
    end else if (tail_v) begin
      if (tail_l) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_nxt;
        cnt <= cnt_nxt;
      end
    end
  end

  pe_res_fifo #(
    .T     (res_w_t),
    .DEPTH (RES_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (push_res),
    .pop    (out_ready),
    .dout   (head),
    .valid  (out_valid),
    .count  (fifo_cnt)
  );

  assign out_sum    = head.sum;
  assign out_chunks = head.chunks;
  assign busy       = (|vld_pipe) || (cnt != '0);

endmodule

// File: tb/tb_pe_dot_accum_ctrl.sv
// Directed bench for pe_dot_accum_ctrl at NUM=4, DIN_W=8 (tree latency 2), RES_DEPTH=4.
module tb_pe_dot_accum_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic [15:0] out_chunks;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] pop_sum_q[$];
  logic [15:0] pop_cnt_q[$];

  pe_dot_accum_ctrl #(
    .NUM(4), .DIN_W(8), .ACC_W(32), .CNT_W(16), .RES_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_chunks(out_chunks),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every pop; inputs only change #1 after posedge, so negedge is stable.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      pop_sum_q.push_back(out_sum);
      pop_cnt_q.push_back(out_chunks);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = a[7:0]; lb = b[7:0]; lc = c[7:0]; ld = d[7:0];
    return {ld, lc, lb, la};
  endfunction

  // Offer one chunk; returns at posedge+1 after the accepting edge, or after maxw tries.
  task automatic send(input logic [31:0] data, input logic last, input int maxw, output bit ok);
    in_valid = 1'b1; in_data = data; in_last = last; ok = 1'b0;
    for (int i = 0; i < maxw && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int nacc;
    resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_chunks", out_chunks, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Single chunk: visible two edges after the accepting edge.
    send(lanes(1, 2, 3, 4), 1'b1, 4, ok);
    chk("t1_accept", ok, 1);
    @(negedge clk); chk("t1_lat_e0", out_valid, 0);
    @(negedge clk); chk("t1_lat_e1", out_valid, 0);
    @(negedge clk); chk("t1_lat_e2", out_valid, 1);
    chk("t1_sum", out_sum, 10);
    chk("t1_chunks", out_chunks, 1);
    pop_one();

    // Three back-to-back chunks: 4 - 8 + 508 = 504.
    send(lanes(1, 1, 1, 1), 1'b0, 4, ok);
    chk("t2_accept0", ok, 1);
    chk("t2_busy", busy, 1);
    send(lanes(-2, -2, -2, -2), 1'b0, 4, ok);
    chk("t2_accept1", ok, 1);
    send(lanes(127, 127, 127, 127), 1'b1, 4, ok);
    chk("t2_accept2", ok, 1);
    wait_out(10, ok);
    chk("t2_out", ok, 1);
    chk("t2_sum", out_sum, 504);
    chk("t2_chunks", out_chunks, 3);
    chk("t2_busy_done", busy, 0);
    pop_one();
    @(negedge clk); chk("t2_empty", out_valid, 0);

    // Credit throttling with a stalled consumer.
    @(posedge clk); #1;
    pop_sum_q.delete(); pop_cnt_q.delete();
    nacc = 0;
    for (int k = 1; k <= 6; k++) begin
      if (nacc == k - 1) begin
        send(lanes(k, 0, 0, 0), 1'b1, 8, ok);
        if (ok) nacc++;
      end
    end
    chk("t3_accepted", nacc, 4);
    @(negedge clk);
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(lanes(5, 0, 0, 0), 1'b1, 20, ok);
    chk("t3_accept5", ok, 1);
    send(lanes(6, 0, 0, 0), 1'b1, 20, ok);
    chk("t3_accept6", ok, 1);
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("t3_pops", pop_sum_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_sum%0d", i), pop_sum_q[i], i + 1);
      chk($sformatf("t3_cnt%0d", i), pop_cnt_q[i], 1);
    end

    // Sign extension of the most negative lanes.
    send(lanes(-128, -128, -128, -128), 1'b1, 4, ok);
    chk("t4_accept", ok, 1);
    wait_out(10, ok);
    chk("t4_out", ok, 1);
    chk("t4_sum", out_sum, 32'hFFFF_FE00);
    chk("t4_chunks", out_chunks, 1);
    pop_one();

    // Reset mid-frame discards the partial accumulation.
    send(lanes(1, 1, 1, 1), 1'b0, 4, ok);
    chk("t5_accept0", ok, 1);
    @(posedge clk); @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    send(lanes(5, 0, 0, 0), 1'b1, 4, ok);
    chk("t5_accept1", ok, 1);
    wait_out(10, ok);
    chk("t5_out", ok, 1);
    chk("t5_sum", out_sum, 5);
    chk("t5_chunks", out_chunks, 1);
    pop_one();

    // Pop and last-retire on the same edge with three entries queued.
    @(posedge clk); #1;
    pop_sum_q.delete(); pop_cnt_q.delete();
    for (int k = 1; k <= 3; k++) begin
      send(lanes(k, 0, 0, 0), 1'b1, 6, ok);
      chk($sformatf("t6_fill%0d", k), ok, 1);
    end
    repeat (6) @(posedge clk); #1;
    @(negedge clk); chk("t6_ready_3", in_ready, 1);
    @(posedge clk); #1;
    send(lanes(4, 0, 0, 0), 1'b1, 4, ok);
    chk("t6_accept4", ok, 1);
    @(negedge clk); chk("t6_ready_credit", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("t6_ready_after", in_ready, 1);
    chk("t6_head", out_sum, 2);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk); chk("t6_drained", out_valid, 0);
    chk("t6_pops", pop_sum_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_sum%0d", i), pop_sum_q[i], i + 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
